ifu_npc: RTL



---
 rtl/ifu_pkg.sv | 20 ++
 rtl/im_ram.sv | 25 ++
 rtl/ifu_npc.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: next-PC select encoding,
// default reset PC and the branch-offset helper.
package ifu_pkg;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;

  // Next-PC select produced by the control decoder.
  typedef enum logic [1:0] {
    NPC_PC4 = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_src_e;

  // beq displacement: sign-extended word offset converted to bytes.
  function automatic logic [31:0] br_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/im_ram.sv
// Instruction memory: 2**AW x 32 words, combinational read port and a
// synchronous loader write port. Contents are not reset.
module im_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // A write lands on the edge, so a same-cycle read still sees the old word.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ifu_npc.sv
// Fetch unit: PC register, next-PC mux (seq/beq/j/jal/jr), retire counter and
// sticky address-error flag. Define DELAY_SLOT_EN for MIPS branch-delay slots.
module ifu_npc
  import ifu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter int          IM_AW    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [1:0]       npc_src,
  input  logic             zero,
  input  logic [31:0]      ra_data,
  input  logic             im_we,
  input  logic [IM_AW-1:0] im_waddr,
  input  logic [31:0]      im_wdata,
  output logic [31:0]      instr,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [31:0]      icount,
  output logic             addr_err
);

  logic [31:0] r_pc;
  logic [31:0] r_icount;
  logic        r_addr_err;

  logic [29:0]      w_widx;
  logic             w_in_range;
  logic [IM_AW-1:0] w_raddr;
  logic [31:0]      w_ram_word;
  logic [31:0]      w_instr;
  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_target;
  logic             w_redirect;
  logic             w_jr_misalign;
  logic [31:0]      w_npc;
  npc_src_e         w_src;

  // Word offset from the memory base; anything outside the window fetches a nop.
  assign w_widx     = r_pc[31:2] - PC_RESET[31:2];
  assign w_in_range = (w_widx[29:IM_AW] == '0);
  assign w_raddr    = w_widx[IM_AW-1:0];

  im_ram #(
    .AW (IM_AW)
  ) u_im_ram (
    .clk     (clk),
    .i_we    (im_we),
    .i_waddr (im_waddr),
    .i_wdata (im_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_word)
  );

  assign w_instr    = w_in_range ? w_ram_word : 32'h0000_0000;
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_src      = npc_src_e'(npc_src);

  always_comb begin
    w_target      = w_pc_plus4;
    w_redirect    = 1'b0;
    w_jr_misalign = 1'b0;
    case (w_src)
      NPC_PC4: begin
        w_target = w_pc_plus4;
      end
      NPC_BR: begin
        if (zero) begin
          w_target   = w_pc_plus4 + br_offset(w_instr[15:0]);
          w_redirect = 1'b1;
        end
      end
      NPC_J: begin
        w_target   = {w_pc_plus4[31:28], w_instr[25:0], 2'b00};
        w_redirect = 1'b1;
      end
      NPC_JR: begin
        w_target      = {ra_data[31:2], 2'b00};
        w_redirect    = 1'b1;
        w_jr_misalign = (ra_data[1:0] != 2'b00);
      end
      default: begin
        w_target = w_pc_plus4;
      end
    endcase
  end

`ifdef DELAY_SLOT_EN
  logic        r_pend_valid;
  logic [31:0] r_pend_target;

  // The slot after a taken redirect always runs pc+4; a pending target wins
  // over any redirect issued from inside the slot.
  assign w_npc = r_pend_valid ? r_pend_target : w_pc_plus4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_valid  <= 1'b0;
      r_pend_target <= PC_RESET;
    end else if (!stall) begin
      if (r_pend_valid) begin
        r_pend_valid <= 1'b0;
      end else if (w_redirect) begin
        r_pend_valid  <= 1'b1;
        r_pend_target <= w_target;
      end
    end
  end
`else
  assign w_npc = w_redirect ? w_target : w_pc_plus4;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= PC_RESET;
      r_icount <= 32'd0;
    end else if (!stall) begin
      r_pc     <= w_npc;
      r_icount <= r_icount + 32'd1;
    end
  end

  // Error capture ignores stall so a bad fetch or jr is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_err <= 1'b0;
    end else if (!w_in_range || w_jr_misalign) begin
      r_addr_err <= 1'b1;
    end
  end

  assign instr    = w_instr;
  assign pc       = r_pc;
  assign pc_plus4 = w_pc_plus4;
  assign icount   = r_icount;
  assign addr_err = r_addr_err;

endmodule
